// File: rtl/pipe_pkg.sv
// Shared types for the pipe skid stage: the holding-state enumeration and
// the occupancy encoding derived from it.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  function automatic logic [OCC_W-1:0] state_occ(input state_e s);
    case (s)
      EMPTY:   return 2'd0;
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload slot: a W-bit register that resets to the bubble value and
// captures d when load is high.
module pipe_slot #(
  parameter int             W      = 8,
  parameter logic [W-1:0]   BUBBLE = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // payload register, cleared to the bubble value by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= BUBBLE;
    end else if (load) begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage: two-entry skid buffer with a registered in_ready
// (SKID=1) or a single register with combinational in_ready (SKID=0).
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int           W      = 154,
  parameter logic [W-1:0] BUBBLE = {W{1'b0}},
  parameter bit           SKID   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [OCC_W-1:0] occupancy
);

  state_e             state_r;
  state_e             next_state_s;
  logic               out_valid_r;
  logic [OCC_W-1:0]   occupancy_r;
  logic               in_xfer_s;
  logic               out_xfer_s;
  logic               main_load_s;
  logic [W-1:0]       main_d_s;
  logic [W-1:0]       main_q_s;

  assign in_xfer_s  = in_valid & in_ready & ~flush;
  assign out_xfer_s = out_valid_r & out_ready;

  // state and the status outputs that are decoded from it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= next_state_s;
      out_valid_r <= (next_state_s != EMPTY);
      occupancy_r <= state_occ(next_state_s);
    end
  end

  // The main slot is reloaded with BUBBLE whenever it empties, so out_data
  // shows the bubble value without an output mux.
  pipe_slot #(.W(W), .BUBBLE(BUBBLE)) u_main_slot (
    .clk  (clk),
    .rst  (rst),
    .load (main_load_s),
    .d    (main_d_s),
    .q    (main_q_s)
  );

  assign out_valid = out_valid_r;
  assign out_data  = main_q_s;
  assign occupancy = occupancy_r;

  if (SKID) begin : g_skid
    logic         in_ready_r;
    logic         skid_load_s;
    logic [W-1:0] skid_d_s;
    logic [W-1:0] skid_q_s;

    // next-state and slot steering for the two-entry buffer
    always_comb begin
      next_state_s = state_r;
      main_load_s  = 1'b0;
      main_d_s     = in_data;
      skid_load_s  = 1'b0;
      skid_d_s     = in_data;
      if (flush) begin
        next_state_s = EMPTY;
        main_load_s  = 1'b1;
        main_d_s     = BUBBLE;
        skid_load_s  = 1'b1;
        skid_d_s     = BUBBLE;
      end else begin
        case (state_r)
          EMPTY: begin
            if (in_xfer_s) begin
              next_state_s = ONE;
              main_load_s  = 1'b1;
            end else begin
              next_state_s = EMPTY;
            end
          end
          ONE: begin
            if (in_xfer_s && out_xfer_s) begin
              main_load_s  = 1'b1;
            end else if (in_xfer_s) begin
              next_state_s = TWO;
              skid_load_s  = 1'b1;
            end else if (out_xfer_s) begin
              next_state_s = EMPTY;
              main_load_s  = 1'b1;
              main_d_s     = BUBBLE;
            end else begin
              next_state_s = ONE;
            end
          end
          TWO: begin
            if (out_xfer_s) begin
              next_state_s = ONE;
              main_load_s  = 1'b1;
              main_d_s     = skid_q_s;
              skid_load_s  = 1'b1;
              skid_d_s     = BUBBLE;
            end else begin
              next_state_s = TWO;
            end
          end
          default: begin
            next_state_s = EMPTY;
            main_load_s  = 1'b1;
            main_d_s     = BUBBLE;
            skid_load_s  = 1'b1;
            skid_d_s     = BUBBLE;
          end
        endcase
      end
    end

    // in_ready looks only at the next state, never at out_ready directly
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        in_ready_r <= 1'b1;
      end else begin
        in_ready_r <= (next_state_s != TWO);
      end
    end

    assign in_ready = in_ready_r;

    pipe_slot #(.W(W), .BUBBLE(BUBBLE)) u_skid_slot (
      .clk  (clk),
      .rst  (rst),
      .load (skid_load_s),
      .d    (skid_d_s),
      .q    (skid_q_s)
    );
  end else begin : g_single
    assign in_ready = ~out_valid_r | out_ready;

    // next-state and load control for the single register
    always_comb begin
      next_state_s = state_r;
      main_load_s  = 1'b0;
      main_d_s     = in_data;
      if (flush) begin
        next_state_s = EMPTY;
        main_load_s  = 1'b1;
        main_d_s     = BUBBLE;
      end else begin
        case (state_r)
          EMPTY: begin
            if (in_xfer_s) begin
              next_state_s = ONE;
              main_load_s  = 1'b1;
            end else begin
              next_state_s = EMPTY;
            end
          end
          ONE: begin
            if (in_xfer_s) begin
              main_load_s  = 1'b1;
            end else if (out_xfer_s) begin
              next_state_s = EMPTY;
              main_load_s  = 1'b1;
              main_d_s     = BUBBLE;
            end else begin
              next_state_s = ONE;
            end
          end
          default: begin
            next_state_s = EMPTY;
            main_load_s  = 1'b1;
            main_d_s     = BUBBLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter W, default 154: payload width in bits.
REQ-002 Parameter BUBBLE, default W'(0): payload value presented when no valid entry is held, and loaded on flush and reset.
REQ-003 Parameter SKID, default 1: 1 selects the two-entry skid mode; 0 selects the single-register mode.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream entry is present.
REQ-007 in_ready  output  1  stage accepts an entry this cycle.
REQ-008 in_data  input  W  upstream payload.
REQ-009 flush  input  1  synchronous kill of all held entries.
REQ-010 out_valid  output  1  out_data holds a valid entry.
REQ-011 out_ready  input  1  downstream accepts an entry this cycle.
REQ-012 out_data  output  W  payload of the oldest held entry.
REQ-013 occupancy  output  2  number of held entries, 0..2.

Function
REQ-014 An input transfer SHALL occur when in_valid, in_ready and !flush are all high on a rising edge.
REQ-015 An output transfer SHALL occur when out_valid and out_ready are both high on a rising edge.
REQ-016 Entries SHALL leave in arrival order with no loss or duplication; payload latency SHALL be 1 cycle from input transfer to out_valid.
REQ-017 SKID=1: state SHALL be EMPTY, ONE or TWO; TWO means the main slot and the skid slot are both full.
REQ-018 SKID=1: in_ready SHALL be a registered output, high in EMPTY and ONE, low in TWO, and SHALL have no combinational path from out_ready.
REQ-019 SKID=1 transitions:
- EMPTY + input -> ONE.
- ONE + input + no output -> TWO; the new entry goes to the skid slot.
- ONE + input + output -> ONE; the main slot takes the new entry.
- ONE + output only -> EMPTY.
- TWO + output -> ONE; the skid slot moves to the main slot.
- All other cases hold.
REQ-020 SKID=0: state SHALL be EMPTY or ONE.
REQ-021 SKID=0: in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-022 SKID=0: a simultaneous input and output transfer SHALL keep ONE and load the new payload.
REQ-023 flush SHALL take priority over every other event: next state EMPTY, in_data discarded, any coincident output transfer still counted as delivered.
REQ-024 After a flush edge, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-025 out_data SHALL equal BUBBLE whenever out_valid is 0.
REQ-026 occupancy SHALL equal 0, 1 or 2 for EMPTY, ONE or TWO, registered with the state.
REQ-027 in_valid held high while in_ready is low SHALL NOT change state or stored data.

Reset
REQ-028 While rst is low: out_valid=0, out_data=BUBBLE, occupancy=0, state=EMPTY, skid slot=BUBBLE.
REQ-029 While rst is low, in_ready SHALL be 1 in SKID=1 mode and follow REQ-021 in SKID=0 mode.
REQ-030 Reset assertion mid-transfer SHALL discard all held entries immediately, without waiting for a clock edge.
REQ-031 The first input transfer SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-032 Package pipe_pkg SHALL hold the state enumeration (EMPTY, ONE, TWO) and the occupancy width constant.
REQ-033 Each payload slot SHALL be an instance of the sub-module pipe_slot: a W-bit register with async active-low reset to BUBBLE and a load enable.
REQ-034 SKID=0 SHALL instantiate one pipe_slot; SKID=1 SHALL instantiate two.

Verification
REQ-035 SKID=1, W=8, out_ready=1, in_valid=1 with data 0x01..0x05 on consecutive cycles -> out_data 0x01..0x05 one cycle later each; occupancy stays 1; in_ready stays 1.
REQ-036 SKID=1, out_ready=0, push 0xA1 then 0xA2 -> occupancy=2 and in_ready=0 next cycle; 0xA3 is held off; then out_ready=1 -> 0xA1, 0xA2, 0xA3 in order.
REQ-037 SKID=1, state TWO, flush=1 with in_valid=1 and in_data=0x55 -> next cycle out_valid=0, out_data=BUBBLE, occupancy=0, in_ready=1; 0x55 never appears at the output.
REQ-038 SKID=0, out_valid=1, out_ready=1, in_valid=1 with data 0x3C -> same-cycle in_ready=1; next cycle out_data=0x3C, occupancy=1.
REQ-039 rst pulsed low mid-cycle while in TWO -> out_valid=0 and occupancy=0 immediately; first post-reset push of 0x7E appears after 1 cycle.
REQ-040 Random in_valid/out_ready/flush traffic over 10k cycles, both SKID values -> scoreboard shows in-order delivery, no loss except flushed entries, and out_data=BUBBLE whenever out_valid=0.
